// File: rtl/p2s_pkg.sv
// Shared types and width helpers for the parallel-to-serial display shifter.
package p2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DONE
  } p2s_state_t;

  function automatic int unsigned hp_cnt_width(input int unsigned half_period);
    return $clog2(half_period + 1);
  endfunction

  function automatic int unsigned bit_cnt_width(input int unsigned data_bits);
    return $clog2(data_bits);
  endfunction

endpackage

// File: rtl/p2s_tick_gen.sv
// Half-period timer: tick_c marks the last clk cycle of each serial-clock phase.
module p2s_tick_gen
  import p2s_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CW = hp_cnt_width(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD);

  logic [CW-1:0] cnt;

  assign tick_c = (cnt == LAST);

  // Counts 1..HALF_PERIOD within a phase; reloads on restart or at the phase end.
  always_ff @(posedge clk) begin
    if (rst || restart || tick_c) begin
      cnt <= CW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial shifter for 74HC595-style chains: captures a word on a start
// edge, shifts it out with a divided s_clk, then strobes s_latch and pulses done.
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] pdata,
  output logic                 busy,
  output logic                 done,
  output logic                 s_clk,
  output logic                 s_clrn,
  output logic                 sout,
  output logic                 s_latch
);

  localparam int unsigned BW = bit_cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam bit MSB = (MSB_FIRST != 0);

  p2s_state_t           state;
  logic                 start_q;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_shift_c;
  logic [BW-1:0]        bitcnt;
  logic                 start_edge_c;
  logic                 restart_c;
  logic                 tick_c;

  assign start_edge_c  = start & ~start_q;
  assign restart_c     = (state == ST_LOAD);
  assign shreg_shift_c = MSB ? {shreg[DATA_BITS-2:0], 1'b0} : {1'b0, shreg[DATA_BITS-1:1]};

  function automatic logic head(input logic [DATA_BITS-1:0] w);
    return MSB ? w[DATA_BITS-1] : w[0];
  endfunction

  p2s_tick_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Control FSM; outputs are set on the transition into the state they belong to.
  always_ff @(posedge clk) begin
    start_q <= start;
    s_clrn  <= ~rst;
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_latch <= 1'b0;
      sout    <= 1'b0;
      shreg   <= '0;
      bitcnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge_c) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          shreg  <= pdata;
          bitcnt <= '0;
          sout   <= head(pdata);
          state  <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO: begin
          if (tick_c) begin
            s_clk <= 1'b1;
            state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (tick_c) begin
            s_clk <= 1'b0;
            if (bitcnt == LAST_BIT) begin
              s_latch <= 1'b1;
              state   <= ST_LATCH;
            end else begin
              shreg  <= shreg_shift_c;
              sout   <= head(shreg_shift_c);
              bitcnt <= bitcnt + BW'(1);
              state  <= ST_SHIFT_LO;
            end
          end
        end
        ST_LATCH: begin
          if (tick_c) begin
            s_latch <= 1'b0;
            sout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: three configurations, a receiver model that samples
// sout on each s_clk rise, and per-scenario timing and data checks.
module tb_p2s_serializer;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic [15:0] pd_a = '0;
  logic [15:0] pd_b = '0;
  logic [7:0]  pd_c = '0;
  wire  [2:0]  busy, done, s_clk, s_clrn, sout, s_latch;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  int          nrise[NI], nlatch[NI], nbusy[NI], ndone[NI], k_cyc[NI], done_cyc[NI];
  logic [63:0] rx[NI];
  logic [2:0]  sclk_p = '0;
  logic [2:0]  busy_p = '0;

  p2s_serializer #(.DATA_BITS(16), .HALF_PERIOD(2), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .pdata(pd_a), .busy(busy[0]), .done(done[0]),
    .s_clk(s_clk[0]), .s_clrn(s_clrn[0]), .sout(sout[0]), .s_latch(s_latch[0]));
  p2s_serializer #(.DATA_BITS(16), .HALF_PERIOD(2), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .pdata(pd_b), .busy(busy[1]), .done(done[1]),
    .s_clk(s_clk[1]), .s_clrn(s_clrn[1]), .sout(sout[1]), .s_latch(s_latch[1]));
  p2s_serializer #(.DATA_BITS(8), .HALF_PERIOD(1), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .pdata(pd_c), .busy(busy[2]), .done(done[2]),
    .s_clk(s_clk[2]), .s_clrn(s_clrn[2]), .sout(sout[2]), .s_latch(s_latch[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int db_of(input int i);
    return (i == 2) ? 8 : 16;
  endfunction
  function automatic int hp_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction
  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  // Word the chain should have received: bits in transmission order, first bit highest.
  function automatic logic [63:0] exp_rx(input int i, input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < db_of(i); j++)
      r = {r[62:0], msb_of(i) ? w[db_of(i)-1-j] : w[j]};
    return r;
  endfunction

  // Receiver / observer model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (s_clk[i] && !sclk_p[i]) begin
        rx[i] = {rx[i][62:0], sout[i]};
        nrise[i]++;
      end
      if (busy[i] && !busy_p[i] && k_cyc[i] < 0) k_cyc[i] = cyc;
      if (busy[i]) nbusy[i]++;
      if (s_latch[i]) nlatch[i]++;
      if (done[i]) begin
        ndone[i]++;
        if (done_cyc[i] < 0) done_cyc[i] = cyc;
      end
    end
    sclk_p = s_clk;
    busy_p = busy;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon(input int i);
    rx[i] = '0; nrise[i] = 0; nlatch[i] = 0; nbusy[i] = 0; ndone[i] = 0;
    k_cyc[i] = -1; done_cyc[i] = -1;
  endtask

  task automatic set_pd(input int i, input logic [63:0] w);
    case (i)
      0:       pd_a = w[15:0];
      1:       pd_b = w[15:0];
      default: pd_c = w[7:0];
    endcase
  endtask

  // One transaction: start edge, scramble pdata once the word is captured, wait for done.
  task automatic do_txn(input int i, input logic [63:0] w, output bit ok);
    int n;
    clear_mon(i);
    set_pd(i, w);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    n = 0;
    while (!busy[i] && n < 10) begin tick(); n++; end
    tick();
    set_pd(i, ~w);
    n = 0;
    while (ndone[i] == 0 && n < 400) begin tick(); n++; end
    ok = (ndone[i] != 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy[i], done[i], s_clk[i], s_latch[i], sout[i], s_clrn[i]} !== 6'b0)
        $display("FAIL reset_outputs[%0d]: got %b want 000000", i,
                 {busy[i], done[i], s_clk[i], s_latch[i], sout[i], s_clrn[i]});
      else passes++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (s_clrn !== 3'b111) $display("FAIL s_clrn_release: got %b want 111", s_clrn);
    else passes++;
  endtask

  // Several words per configuration: data order, s_clk count, latch width and latency.
  task automatic test_txns(input int i, input logic [63:0] first, input int nwords);
    logic [63:0] w, mask;
    bit ok;
    int lat;
    mask = (64'd1 << db_of(i)) - 64'd1;
    lat  = 1 + hp_of(i) * (2 * db_of(i) + 1);
    for (int t = 0; t < nwords; t++) begin
      w = (t == 0) ? first : ({$urandom, $urandom} & mask);
      do_txn(i, w, ok);
      checks++;
      if (!ok) $display("FAIL done_timeout[%0d]: no done within budget", i); else passes++;
      checks++;
      if (rx[i] !== exp_rx(i, w)) $display("FAIL word[%0d]: got %h want %h", i, rx[i], exp_rx(i, w));
      else passes++;
      checks++;
      if (nrise[i] != db_of(i)) $display("FAIL rises[%0d]: got %0d want %0d", i, nrise[i], db_of(i));
      else passes++;
      checks++;
      if (nlatch[i] != hp_of(i)) $display("FAIL latch_len[%0d]: got %0d want %0d", i, nlatch[i], hp_of(i));
      else passes++;
      checks++;
      if (done_cyc[i] - k_cyc[i] != lat)
        $display("FAIL done_latency[%0d]: got %0d want %0d", i, done_cyc[i] - k_cyc[i], lat);
      else passes++;
      checks++;
      if (nbusy[i] != lat) $display("FAIL busy_len[%0d]: got %0d want %0d", i, nbusy[i], lat);
      else passes++;
      checks++;
      if (ndone[i] != 1) $display("FAIL done_count[%0d]: got %0d want 1", i, ndone[i]);
      else passes++;
      checks++;
      if ({s_clk[i], s_latch[i], sout[i], busy[i]} !== 4'b0)
        $display("FAIL idle_levels[%0d]: got %b want 0000", i, {s_clk[i], s_latch[i], sout[i], busy[i]});
      else passes++;
    end
  endtask

  task automatic test_start_held();
    logic [63:0] w;
    bit pulsed;
    w = {48'd0, 16'($urandom)};
    clear_mon(0);
    set_pd(0, w);
    pulsed = 1'b0;
    start[0] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (nrise[0] == 5 && !pulsed) begin
        start[0] = 1'b0;
        tick();
        start[0] = 1'b1;
        pulsed = 1'b1;
      end
    end
    start[0] = 1'b0;
    repeat (3) tick();
    checks++;
    if (ndone[0] != 1) $display("FAIL held_done_count: got %0d want 1", ndone[0]); else passes++;
    checks++;
    if (rx[0] !== exp_rx(0, w)) $display("FAIL held_word: got %h want %h", rx[0], exp_rx(0, w));
    else passes++;
    checks++;
    if (nrise[0] != 16) $display("FAIL held_rises: got %0d want 16", nrise[0]); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] w;
    bit ok;
    int n;
    clear_mon(0);
    set_pd(0, 64'h0000_0000_0000_C3A5);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (nrise[0] < 6 && n < 200) begin tick(); n++; end
    checks++;
    if (nrise[0] < 6) $display("FAIL mid_wait: got %0d rises want 6", nrise[0]); else passes++;
    rst = 1'b1;
    tick();
    checks++;
    if ({busy[0], done[0], s_clk[0], s_latch[0], sout[0], s_clrn[0]} !== 6'b0)
      $display("FAIL mid_reset_outputs: got %b want 000000",
               {busy[0], done[0], s_clk[0], s_latch[0], sout[0], s_clrn[0]});
    else passes++;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (nlatch[0] != 0 || ndone[0] != 0)
      $display("FAIL mid_no_pulses: got latch=%0d done=%0d want 0 0", nlatch[0], ndone[0]);
    else passes++;
    w = {48'd0, 16'($urandom)};
    do_txn(0, w, ok);
    checks++;
    if (!ok || rx[0] !== exp_rx(0, w))
      $display("FAIL mid_new_word: got %h want %h", rx[0], exp_rx(0, w));
    else passes++;
    checks++;
    if (nrise[0] != 16) $display("FAIL mid_new_rises: got %0d want 16", nrise[0]); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] w1;
    int n;
    w1 = {48'd0, 16'($urandom)};
    clear_mon(0);
    set_pd(0, w1);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 300) begin tick(); n++; end
    checks++;
    if (!done[0]) $display("FAIL b2b_first_done: got 0 want 1"); else passes++;
    start[0] = 1'b1;
    set_pd(0, 64'h0F0F);
    tick();
    checks++;
    if (busy[0] !== 1'b1) $display("FAIL b2b_no_gap: got busy=%b want 1", busy[0]); else passes++;
    start[0] = 1'b0;
    n = 0;
    while (ndone[0] < 2 && n < 300) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (ndone[0] != 2) $display("FAIL b2b_done_count: got %0d want 2", ndone[0]); else passes++;
    checks++;
    if (rx[0][31:0] !== {exp_rx(0, w1)[15:0], 16'h0F0F})
      $display("FAIL b2b_words: got %h want %h", rx[0][31:0], {exp_rx(0, w1)[15:0], 16'h0F0F});
    else passes++;
    checks++;
    if (nrise[0] != 32) $display("FAIL b2b_rises: got %0d want 32", nrise[0]); else passes++;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) clear_mon(i);
    test_reset();
    test_txns(0, 64'hA5C3, 4);
    test_txns(1, 64'hA5C3, 4);
    test_txns(2, 64'h81, 4);
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
